// File: rtl/pe_ws_vec.sv
// Weight-stationary vector PE: LANES parallel MACs fed from a local weight scratchpad,
// with the K/N/M weight-reuse loops sequenced by internal counters and a 2-stage MAC pipeline.
module pe_ws_vec #(
  parameter int OP_WIDTH  = 8,
  parameter int ACC_WIDTH = 20,
  parameter int LANES     = 4,
  parameter int DEPTH     = 64,
  parameter int SAT       = 0,
  parameter     MEM_INIT  = "zero.txt",
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_valid,
  input  logic [LANES*OP_WIDTH-1:0]    w_data,
  output logic                         w_ready,
  input  logic                         w_clear,
  input  logic                         start,
  input  logic [AW:0]                  cfg_k,
  input  logic [AW:0]                  cfg_n,
  input  logic [AW:0]                  cfg_m,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_WIDTH-1:0]          iact,
  input  logic [LANES*ACC_WIDTH-1:0]   psum_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*ACC_WIDTH-1:0]   psum_out,
  output logic                         busy,
  output logic                         done,
  output logic [AW:0]                  w_count
);

  localparam int WW = LANES * OP_WIDTH;
  localparam int PW = LANES * ACC_WIDTH;
  localparam logic [AW:0] ONE     = (AW + 1)'(1);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);
  localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] s);
    if (SAT != 0 && s > ACC_MAX) return ACC_MAX[ACC_WIDTH-1:0];
    if (SAT != 0 && s < ACC_MIN) return ACC_MIN[ACC_WIDTH-1:0];
    return s[ACC_WIDTH-1:0];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] mac(input logic signed [ACC_WIDTH-1:0] p,
                                                       input logic signed [OP_WIDTH-1:0]  a,
                                                       input logic signed [OP_WIDTH-1:0]  w);
    logic signed [2*OP_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH:0]    sum;
    prod = a * w;
    sum  = (ACC_WIDTH + 1)'(p) + (ACC_WIDTH + 1)'(prod);
    return sat_acc(sum);
  endfunction

  function automatic logic [AW:0] fix_cfg(input logic [AW:0] c);
    return (c == '0) ? ONE : c;
  endfunction

  logic [WW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW:0]   w_count_q, w_count_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   k_q, k_d, n_q, n_d, m_q, m_d;
  logic [AW:0]   cfg_k_q, cfg_k_d, cfg_n_q, cfg_n_d, cfg_m_q, cfg_m_d;
  logic          done_q, done_d;
  logic          vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;

  logic [OP_WIDTH-1:0] iact_p1_q, iact_p1_d;
  logic [PW-1:0]       psum_p1_q, psum_p1_d;
  logic [AW-1:0]       addr_p1_q, addr_p1_d;
  logic [WW-1:0]       w_p1_q, w_p1_d;
  logic [PW-1:0]       psum_p2_q, psum_p2_d;

  logic          w_fire, in_fire, out_fire, s2_load;
  logic [AW-1:0] cur_addr, rd_addr;

  assign w_ready   = (state_q == IDLE) && (w_count_q < DEPTH_V);
  assign in_ready  = (state_q == RUN) && !(vld_p1_q && vld_p2_q && !out_ready);
  assign out_valid = vld_p2_q;
  assign psum_out  = vld_p2_q ? psum_p2_q : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign w_count   = w_count_q;

  // w_clear wins over a same-cycle write, so the write is dropped entirely
  assign w_fire   = w_valid && w_ready && !w_clear;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = vld_p2_q && out_ready;
  assign s2_load  = vld_p1_q && (!vld_p2_q || out_ready);
  assign cur_addr = base_q + k_q[AW-1:0];
  // A stalled stage 1 re-reads its held address so the read data stays aligned with it
  assign rd_addr  = in_fire ? cur_addr : addr_p1_q;

  always_comb begin
    state_d   = state_q;
    w_count_d = w_count_q;
    base_d    = base_q;
    k_d       = k_q;
    n_d       = n_q;
    m_d       = m_q;
    cfg_k_d   = cfg_k_q;
    cfg_n_d   = cfg_n_q;
    cfg_m_d   = cfg_m_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_clear)     w_count_d = '0;
        else if (w_fire) w_count_d = w_count_q + ONE;
        if (start) begin
          state_d = RUN;
          cfg_k_d = fix_cfg(cfg_k);
          cfg_n_d = fix_cfg(cfg_n);
          cfg_m_d = fix_cfg(cfg_m);
          base_d  = '0;
          k_d     = '0;
          n_d     = '0;
          m_d     = '0;
        end
      end
      RUN: begin
        if (in_fire) begin
          if (k_q + ONE == cfg_k_q) begin
            k_d = '0;
            if (n_q + ONE == cfg_n_q) begin
              n_d    = '0;
              base_d = base_q + cfg_k_q[AW-1:0];
              if (m_q + ONE == cfg_m_q) begin
                m_d     = '0;
                base_d  = '0;
                state_d = DRAIN;
              end else begin
                m_d = m_q + ONE;
              end
            end else begin
              n_d = n_q + ONE;
            end
          end else begin
            k_d = k_q + ONE;
          end
        end
      end
      DRAIN: begin
        if (out_fire && !vld_p1_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_p1_d  = in_fire | (vld_p1_q & ~s2_load);
    vld_p2_d  = s2_load | (vld_p2_q & ~out_ready);
    iact_p1_d = iact_p1_q;
    psum_p1_d = psum_p1_q;
    addr_p1_d = addr_p1_q;
    if (in_fire) begin
      iact_p1_d = iact;
      psum_p1_d = psum_in;
      addr_p1_d = cur_addr;
    end
    w_p1_d    = mem[rd_addr];
    psum_p2_d = psum_p2_q;
    if (s2_load) begin
      for (int i = 0; i < LANES; i++) begin
        psum_p2_d[i*ACC_WIDTH +: ACC_WIDTH] = mac(psum_p1_q[i*ACC_WIDTH +: ACC_WIDTH], iact_p1_q,
                                                  w_p1_q[i*OP_WIDTH +: OP_WIDTH]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      w_count_q <= '0;
      base_q    <= '0;
      k_q       <= '0;
      n_q       <= '0;
      m_q       <= '0;
      cfg_k_q   <= ONE;
      cfg_n_q   <= ONE;
      cfg_m_q   <= ONE;
      done_q    <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_count_q <= w_count_d;
      base_q    <= base_d;
      k_q       <= k_d;
      n_q       <= n_d;
      m_q       <= m_d;
      cfg_k_q   <= cfg_k_d;
      cfg_n_q   <= cfg_n_d;
      cfg_m_q   <= cfg_m_d;
      done_q    <= done_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  // Stage 1: operands, address and scratchpad read | Stage 2: MAC result
  always_ff @(posedge clk) begin
    iact_p1_q <= iact_p1_d;
    psum_p1_q <= psum_p1_d;
    addr_p1_q <= addr_p1_d;
    w_p1_q    <= w_p1_d;
    psum_p2_q <= psum_p2_d;
  end

  // Scratchpad contents survive reset
  always_ff @(posedge clk) begin
    if (w_fire) mem[w_count_q[AW-1:0]] <= w_data;
  end

endmodule

// File: tb/tb_pe_ws_vec.sv
// Scoreboard bench for pe_ws_vec: a wrapping and a saturating instance share all stimulus.
module tb_pe_ws_vec;

  logic        clk = 1'b0;
  logic        rst, w_valid, w_clear, start, in_valid, out_ready;
  logic [31:0] w_data;
  logic [6:0]  cfg_k, cfg_n, cfg_m;
  logic [7:0]  iact;
  logic [79:0] psum_in;

  logic        w_ready0, in_ready0, out_valid0, busy0, done0;
  logic        w_ready1, in_ready1, out_valid1, busy1, done1;
  logic [79:0] psum_out0, psum_out1;
  logic [6:0]  w_count0, w_count1;

  pe_ws_vec #(.OP_WIDTH(8), .ACC_WIDTH(20), .LANES(4), .DEPTH(64), .SAT(0), .MEM_INIT("zero.txt")) dut0 (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready0), .w_clear(w_clear),
    .start(start), .cfg_k(cfg_k), .cfg_n(cfg_n), .cfg_m(cfg_m), .in_valid(in_valid), .in_ready(in_ready0),
    .iact(iact), .psum_in(psum_in), .out_valid(out_valid0), .out_ready(out_ready), .psum_out(psum_out0),
    .busy(busy0), .done(done0), .w_count(w_count0));

  pe_ws_vec #(.OP_WIDTH(8), .ACC_WIDTH(20), .LANES(4), .DEPTH(64), .SAT(1), .MEM_INIT("zero.txt")) dut1 (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready1), .w_clear(w_clear),
    .start(start), .cfg_k(cfg_k), .cfg_n(cfg_n), .cfg_m(cfg_m), .in_valid(in_valid), .in_ready(in_ready1),
    .iact(iact), .psum_in(psum_in), .out_valid(out_valid1), .out_ready(out_ready), .psum_out(psum_out1),
    .busy(busy1), .done(done1), .w_count(w_count1));

  initial forever #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [79:0] q0[$], q1[$];
  longint lane0_hist[$];
  longint last0, last1;
  int n_out0, n_out1, done_cnt;
  bit bp_en = 1'b0;
  logic [31:0] wmem [64];
  int wcnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic longint s20(input logic [19:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint wrap20(input longint s);
    longint t;
    t = s & 64'hFFFFF;
    if (t >= 524288) t = t - 1048576;
    return t;
  endfunction

  function automatic longint sat20(input longint s);
    if (s > 524287) return 524287;
    if (s < -524288) return -524288;
    return s;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on every output handshake and checks hold stability
  initial begin
    bit hold0 = 0, hold1 = 0;
    logic [79:0] hval0, hval1, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold0 = 0;
        hold1 = 0;
      end else begin
        if (hold0) chkv("stable0", psum_out0, hval0);
        if (hold1) chkv("stable1", psum_out1, hval1);
        hold0 = out_valid0 && !out_ready;
        hval0 = psum_out0;
        hold1 = out_valid1 && !out_ready;
        hval1 = psum_out1;
        if (out_valid0 && out_ready) begin
          if (q0.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL extra_out0: actual %h required no output", psum_out0);
          end else begin
            e = q0.pop_front();
            chkv("psum0", psum_out0, e);
            n_out0++;
            last0 = s20(psum_out0[19:0]);
            lane0_hist.push_back(last0);
          end
        end
        if (out_valid1 && out_ready) begin
          if (q1.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL extra_out1: actual %h required no output", psum_out1);
          end else begin
            e = q1.pop_front();
            chkv("psum1", psum_out1, e);
            n_out1++;
            last1 = s20(psum_out1[19:0]);
          end
        end
        if (done0) done_cnt++;
      end
    end
  end

  task automatic wr(input logic [31:0] v, input bit with_start, input int ck, input int cn, input int cm);
    w_valid = 1'b1;
    w_data  = v;
    start   = with_start;
    cfg_k   = 7'(ck);
    cfg_n   = 7'(cn);
    cfg_m   = 7'(cm);
    @(negedge clk);
    chk("w_ready", w_ready0, (wcnt < 64) ? 1 : 0);
    @(posedge clk);
    if (wcnt < 64) begin
      wmem[wcnt] = v;
      wcnt++;
    end
    #1;
    w_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic clr();
    w_clear = 1'b1;
    sync();
    w_clear = 1'b0;
    wcnt = 0;
  endtask

  task automatic do_start(input int ck, input int cn, input int cm);
    n_out0 = 0; n_out1 = 0; done_cnt = 0;
    lane0_hist.delete();
    start = 1'b1;
    cfg_k = 7'(ck); cfg_n = 7'(cn); cfg_m = 7'(cm);
    sync();
    start = 1'b0;
  endtask

  // Walks the m/n/k loops in order; the expected result of each accepted beat is pushed at acceptance
  task automatic issue_beats(input int ck, input int cn, input int cm, input bit rnd,
                             input int fi, input int fp, input int abort_after, output int issued);
    int ke, ne, me, a, addr, t;
    int ps[4];
    longint w, s, r0, r1;
    logic [79:0] e0, e1;
    ke = (ck == 0) ? 1 : ck;
    ne = (cn == 0) ? 1 : cn;
    me = (cm == 0) ? 1 : cm;
    issued = 0;
    for (int m = 0; m < me; m++) begin
      for (int n = 0; n < ne; n++) begin
        for (int k = 0; k < ke; k++) begin
          if (abort_after >= 0 && issued == abort_after) begin
            in_valid = 1'b0;
            return;
          end
          if (rnd && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            sync();
          end
          a = rnd ? int'($urandom_range(0, 255)) - 128 : fi;
          for (int l = 0; l < 4; l++) begin
            ps[l] = rnd ? int'($urandom_range(0, 1048575)) - 524288 : fp;
            psum_in[l*20 +: 20] = ps[l][19:0];
          end
          iact     = a[7:0];
          in_valid = 1'b1;
          t = 0;
          do begin
            @(negedge clk);
            t++;
          end while (!in_ready0 && t < 100);
          if (!in_ready0) begin
            chk("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
          end
          addr = (m * ke + k) % 64;
          for (int l = 0; l < 4; l++) begin
            w  = longint'($signed(wmem[addr][l*8 +: 8]));
            s  = longint'(ps[l]) + longint'(a) * w;
            r0 = wrap20(s);
            r1 = sat20(s);
            e0[l*20 +: 20] = r0[19:0];
            e1[l*20 +: 20] = r1[19:0];
          end
          q0.push_back(e0);
          q1.push_back(e1);
          sync();
          issued++;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int beats);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done0 && t < 400);
    chk("done", done0, 1);
    chk("done1", done1, 1);
    chk("busy_with_done", busy0, 0);
    chk("beats0", n_out0, beats);
    chk("beats1", n_out1, beats);
    chk("sb_empty", q0.size() + q1.size(), 0);
    sync();
    @(negedge clk);
    chk("done_pulse", done0, 0);
    chk("done_count", done_cnt, 1);
    sync();
  endtask

  task automatic check_reset_outputs();
    chk("rst_w_ready", w_ready0, 1);
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_out_valid", out_valid0, 0);
    chkv("rst_psum_out", psum_out0, '0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_w_count", w_count0, 0);
    chk("rst1_ctrl", {w_ready1, in_ready1, out_valid1, busy1, done1}, 5'b10000);
    chkv("rst1_psum", psum_out1, '0);
    chk("rst1_w_count", w_count1, 0);
  endtask

  initial begin
    int issued;
    logic [31:0] v;
    int exp_seq[12] = '{1, 2, 3, 1, 2, 3, 4, 5, 6, 4, 5, 6};
    rst = 1'b1; w_valid = 0; w_clear = 0; start = 0; in_valid = 0;
    w_data = '0; cfg_k = '0; cfg_n = '0; cfg_m = '0; iact = '0; psum_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    sync();
    rst = 1'b0;

    // Fill the scratchpad, try one more write, then clear
    for (int i = 0; i < 64; i++) wr($urandom, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("full_w_count", w_count0, 64);
    chk("full_w_ready", w_ready0, 0);
    sync();
    wr($urandom, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk("overfill_w_count", w_count0, 64);
    sync();
    clr();
    @(negedge clk);
    chk("clear_w_count", w_count0, 0);
    chk("clear_w_ready", w_ready0, 1);
    sync();

    // Reuse order
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      v[7:0] = 8'(i + 1);
      wr(v, 1'b0, 0, 0, 0);
    end
    do_start(3, 2, 2);
    issue_beats(3, 2, 2, 1'b0, 1, 0, -1, issued);
    wait_done(12);
    for (int i = 0; i < 12; i++) chk("reuse_lane0", (i < lane0_hist.size()) ? lane0_hist[i] : -1, exp_seq[i]);

    // Reset mid-run, then rerun from scratch on the retained weights
    do_start(3, 2, 2);
    issue_beats(3, 2, 2, 1'b0, 1, 0, 5, issued);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    q0.delete(); q1.delete();
    wcnt = 0;
    sync();
    do_start(3, 2, 2);
    issue_beats(3, 2, 2, 1'b0, 1, 0, -1, issued);
    wait_done(12);
    for (int i = 0; i < 12; i++) chk("rerun_lane0", (i < lane0_hist.size()) ? lane0_hist[i] : -1, exp_seq[i]);

    // Arithmetic corners
    clr();
    wr(32'h80808080, 1'b0, 0, 0, 0);
    do_start(1, 1, 1);
    issue_beats(1, 1, 1, 1'b0, -128, 5, -1, issued);
    wait_done(1);
    chk("neg_x_neg_wrap", last0, 16389);
    chk("neg_x_neg_sat", last1, 16389);
    clr();
    wr(32'h01010101, 1'b0, 0, 0, 0);
    do_start(1, 1, 1);
    issue_beats(1, 1, 1, 1'b0, 1, 524287, -1, issued);
    wait_done(1);
    chk("ovf_wrap", last0, -524288);
    chk("ovf_sat", last1, 524287);

    // Random backpressure over a 64-beat run, then an 80-beat run whose addresses wrap
    clr();
    for (int i = 0; i < 64; i++) wr($urandom, 1'b0, 0, 0, 0);
    bp_en = 1'b1;
    do_start(32, 2, 1);
    issue_beats(32, 2, 1, 1'b1, 0, 0, -1, issued);
    wait_done(64);
    do_start(40, 1, 2);
    issue_beats(40, 1, 2, 1'b1, 0, 0, -1, issued);
    wait_done(80);
    bp_en = 1'b0;
    sync();

    // Start together with the final write, all loop bounds zero
    clr();
    n_out0 = 0; n_out1 = 0; done_cnt = 0;
    wr(32'hFD02_7F83, 1'b1, 0, 0, 0);
    issue_beats(0, 0, 0, 1'b0, 3, -7, -1, issued);
    chk("sim_issued", issued, 1);
    @(negedge clk);
    chk("lat_not_yet", out_valid0, 0);
    sync();
    @(negedge clk);
    chk("lat_valid", out_valid0, 1);
    sync();
    wait_done(1);
    chk("sim_lane0", last0, -7 + 3 * (-125));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
